// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: registered pipeline stage with skid buffer, flush and optional stall counter
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   flush      synchronous flush to an empty stage (bubble)
//   in_*       upstream valid/ready/data
//   out_*      downstream valid/ready/data
//   stall_cnt  saturating count of out_valid & !out_ready cycles;
//              present only with macro PIPE_SKID_STALL_CNT_EN, otherwise tied to 0
module pipe_skid_reg #(
    parameter int                 DATA_W    = 64,
    parameter logic [DATA_W-1:0]  RESET_VAL = DATA_W'(0),
    parameter int                 CNT_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] TWO   = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              in_xfer, out_xfer;

    // Handshake outputs come straight from the state register, so there is
    // no combinational path from out_ready to in_ready.
    assign out_valid = state_q != EMPTY;
    assign in_ready  = state_q != TWO;
    assign out_data  = main_q;
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            main_d  = RESET_VAL;
            skid_d  = RESET_VAL;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        main_d  = in_data;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_d = in_data;
                    end else if (in_xfer) begin
                        skid_d  = in_data;
                        state_d = TWO;
                    end else if (out_xfer) begin
                        main_d  = RESET_VAL;
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (out_xfer) begin
                        main_d  = skid_q;
                        skid_d  = RESET_VAL;
                        state_d = ONE;
                    end
                end
                // Unreachable encoding: fall back to an empty stage.
                default: begin
                    state_d = EMPTY;
                    main_d  = RESET_VAL;
                    skid_d  = RESET_VAL;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
            main_q  <= RESET_VAL;
            skid_q  <= RESET_VAL;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

`ifdef PIPE_SKID_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Saturates at all-ones; flush deliberately leaves it untouched.
    always_comb begin
        stall_cnt_d = (out_valid && !out_ready && !(&stall_cnt_q)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg: scoreboard bench for pipe_skid_reg (DATA_W=8, CNT_W=4)
module tb_pipe_skid_reg;
    localparam int         DATA_W = 8;
    localparam int         CNT_W  = 4;
    localparam logic [7:0] RST_V  = 8'hC3;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  stall_cnt;

    int         n_chk = 0;
    int         n_err = 0;
    int         exp_stall = 0;
    logic [7:0] q[$];

    pipe_skid_reg #(.DATA_W(DATA_W), .RESET_VAL(RST_V), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Checks outputs against the queue model at the negedge, then applies the
    // handshake that will happen at the coming posedge to the model.
    task automatic cycle();
        bit mv, mr;
        @(negedge clk);
        mv = q.size() != 0;
        mr = q.size() < 2;
        chk("out_valid", out_valid, mv);
        chk("in_ready", in_ready, mr);
        chk("stall_cnt", stall_cnt, exp_stall);
        chk(mv ? "out_data" : "bubble", out_data, mv ? q[0] : RST_V);
`ifdef PIPE_SKID_STALL_CNT_EN
        if (mv && !out_ready && exp_stall != 15) exp_stall++;
`endif
        if (flush) q.delete();
        else begin
            if (mv && out_ready) void'(q.pop_front());
            if (in_valid && mr) q.push_back(in_data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [7:0] d, input bit r, input bit f);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        cycle();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_data", out_data, RST_V);
        chk("rst_stall", stall_cnt, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // streaming
        drive(1, 8'h11, 1, 0);
        drive(1, 8'h22, 1, 0);
        drive(1, 8'h33, 1, 0);
        drive(0, 8'hEE, 1, 0);
        drive(0, 8'h00, 1, 0);

        // back-pressure into TWO, then drain in order
        drive(1, 8'hA1, 0, 0);
        drive(1, 8'hA2, 0, 0);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_out_data", out_data, 8'hA1);
        drive(1, 8'h77, 0, 0);
        drive(0, 8'h00, 1, 0);
        chk("bp_second", out_data, 8'hA2);
        drive(0, 8'h00, 1, 0);
        drive(0, 8'h00, 1, 0);

        // flush in TWO with a pending 0xFF
        drive(1, 8'h31, 0, 0);
        drive(1, 8'h32, 0, 0);
        drive(1, 8'hFF, 0, 1);
        chk("fl2_out_valid", out_valid, 0);
        chk("fl2_in_ready", in_ready, 1);
        chk("fl2_out_data", out_data, RST_V);
        drive(0, 8'h00, 1, 0);
        // flush in ONE with an acceptable 0xFF: payload must be discarded
        drive(1, 8'h41, 0, 0);
        drive(1, 8'hFF, 1, 1);
        chk("fl1_out_valid", out_valid, 0);
        drive(0, 8'h00, 1, 0);
        drive(0, 8'h00, 1, 0);

        // async reset mid-cycle in ONE
        drive(1, 8'h55, 0, 0);
        in_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_in_ready", in_ready, 1);
        chk("arst_out_data", out_data, RST_V);
        chk("arst_stall", stall_cnt, 0);
        q.delete();
        exp_stall = 0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        drive(1, 8'h66, 1, 0);
        drive(0, 8'h00, 1, 0);

        // stall counter: 20 back-pressured cycles
        drive(1, 8'h99, 0, 0);
        repeat (20) drive(0, 8'h00, 0, 0);
`ifdef PIPE_SKID_STALL_CNT_EN
        chk("stall_sat", stall_cnt, 15);
        drive(0, 8'h00, 0, 1);
        chk("stall_after_flush", stall_cnt, 15);
`else
        chk("stall_off", stall_cnt, 0);
`endif
        drive(0, 8'h00, 1, 0);

        // random valid/ready/flush toggling
        for (int i = 0; i < 10000; i++) begin
            drive(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) != 0),
                  $urandom_range(0, 63) == 0);
        end
        repeat (3) drive(0, 8'h00, 1, 0);
        chk("drained", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
